div_issue_ctrl: RTL
===================

# div_issue_ctrl

EXE-stage initiator for the iterative divider: accepts a DIV/DIVU from the pipeline, drives the divider's start/clear handshake, stalls the pipeline until the result is ready, and captures the remainder/quotient pair for HI/LO write-back. It sits between the ID/EX pipeline register and the divider, and owns all pipeline-side stall and flush handling for divides.

## Interface
- No parameters; the datapath width is fixed at 32 bits for operands and 64 bits for the result.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- div_req_i  in  1  valid DIV/DIVU in EX this cycle.
- div_sign_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- op_a_i  in  32  dividend.
- op_b_i  in  32  divisor.
- flush_i  in  1  exception/flush; kills any divide in progress.
- div_a_o  out  32  dividend to divider (registered copy).
- div_b_o  out  32  divisor to divider (registered copy).
- div_sign_o  out  1  signed flag to divider (registered copy).
- div_start_o  out  1  divider start; held high for the whole operation.
- div_clr_o  out  1  divider clear/abort.
- div_busy_i  in  1  divider busy (combinational from the divider).
- div_result_i  in  64  {remainder[31:0], quotient[31:0]}.
- stall_req_o  out  1  freeze IF/ID/EX while the divide is outstanding.
- hilo_we_o  out  1  one-cycle HI/LO write strobe.
- hi_o  out  32  remainder for HI.
- lo_o  out  32  quotient for LO.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, div_req_i=1, flush_i=0:
  - latch op_a_i, op_b_i and div_sign_i into the div_*_o registers;
  - stall_req_o=1;
  - next state RUN.
- RUN:
  - div_start_o=1.
  - div_busy_i=1: stall_req_o=1; stay in RUN.
  - div_busy_i=0 (the capture cycle): stall_req_o=0, hilo_we_o=1, {hi_o,lo_o}=div_result_i (combinational pass-through); {hi_q,lo_q} load div_result_i; next state DONE.
  - div_req_i is ignored in RUN, since it is the same stalled instruction.
- DONE:
  - div_start_o=0, so the divider returns to its idle state at the end of this cycle.
  - A new div_req_i is accepted exactly as in IDLE (back-to-back divides).
  - With no request, next state IDLE.
- Outside the capture cycle, hi_o/lo_o = hi_q/lo_q.
- flush_i=1 in any state:
  - div_clr_o=1 and div_start_o=0 for that cycle;
  - stall_req_o=0, hilo_we_o=0;
  - next state IDLE; the operand registers hold.
- Flush has priority over capture and over acceptance of a new request.
- Divide by zero needs no special handling: the divider returns result 0, so HI=LO=0.
- Reset: state IDLE; div_a_o, div_b_o, hi_q, lo_q = 0; div_sign_o=0. Outputs div_start_o, div_clr_o, stall_req_o, hilo_we_o = 0; hi_o=lo_o=0.
- A reset asserted mid-operation aborts immediately with no write. The divider is reset by the same rst_n.

## Timing
- Cycle R (request, IDLE/DONE): stall_req_o=1, div_start_o=0; operands registered at the end of R.
- Divider latency, nonzero divisor: div_busy_i=1 for 34 RUN cycles (1 idle-accept + 32 iterations + 1 sign fix-up); the 35th RUN cycle is the capture cycle.
  - stall_req_o is high for exactly 35 consecutive cycles (R plus 34 RUN cycles).
  - hilo_we_o pulses on cycle 36 counted from R.
- Divisor zero: busy for 2 RUN cycles; stall_req_o high for 3 cycles; capture on the 4th.
- div_start_o rises on the first RUN cycle and falls on the first DONE/IDLE cycle.
- div_clr_o is never high in the same cycle as div_start_o.
- hilo_we_o is never high for more than one cycle per accepted request.

## Test plan
- Unsigned 100/7 (div_sign_i=0) -> stall_req_o high 35 cycles; capture cycle hilo_we_o=1, lo_o=14, hi_o=2; hi_o/lo_o hold these values afterwards.
- Signed -7/2 (op_a_i=0xFFFFFFF9, op_b_i=2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- Divisor 0 (op_a_i=0x12345678) -> stall_req_o high 3 cycles; hilo_we_o pulse with hi_o=lo_o=0.
- Flush on RUN cycle 10 -> that cycle div_clr_o=1, div_start_o=0, stall_req_o=0; no hilo_we_o; a new 9/3 issued next cycle completes with lo_o=3, hi_o=0.
- Back-to-back: 50/5 followed by a request in DONE for 0xFFFFFFFF/0x10 unsigned -> two hilo_we_o pulses; second result lo_o=0x0FFFFFFF, hi_o=0xF; div_start_o low for exactly one cycle between the two operations.
- rst_n low on RUN cycle 20 -> all outputs 0 asynchronously; after release, 8/3 completes with lo_o=2, hi_o=2.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: registers operands,
// holds start for the whole operation, stalls the pipeline and captures HI/LO.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_req_i,
    input  logic        div_sign_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_sign_o,
    output logic        div_start_o,
    output logic        div_clr_o,
    input  logic        div_busy_i,
    input  logic [63:0] div_result_i,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        div_sign_q, div_sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        accept;
    logic        capture;

    // Flush outranks both acceptance and capture.
    assign accept  = (state_q != RUN) && div_req_i && !flush_i;
    assign capture = (state_q == RUN) && !div_busy_i && !flush_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = div_req_i ? RUN : IDLE;
            RUN:        state_d = div_busy_i ? RUN : DONE;
            default:    state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a_q    <= '0;
            div_b_q    <= '0;
            div_sign_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            div_sign_q <= div_sign_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        div_sign_d = div_sign_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (accept) begin
            div_a_d    = op_a_i;
            div_b_d    = op_b_i;
            div_sign_d = div_sign_i;
        end
        if (capture) begin
            hi_d = div_result_i[63:32];
            lo_d = div_result_i[31:0];
        end
    end

    // Strobes are gated by rst_n so an asserted reset silences them immediately.
    always_comb begin
        div_start_o = (state_q == RUN) && !flush_i;
        div_clr_o   = flush_i && rst_n;
        stall_req_o = rst_n && !flush_i &&
                      (accept || ((state_q == RUN) && div_busy_i));
        hilo_we_o   = capture && rst_n;
        hi_o        = hilo_we_o ? div_result_i[63:32] : hi_q;
        lo_o        = hilo_we_o ? div_result_i[31:0]  : lo_q;
    end

    assign div_a_o    = div_a_q;
    assign div_b_o    = div_b_q;
    assign div_sign_o = div_sign_q;

endmodule
